// File: rtl/iic_eeprom_slave_pkg.sv
// Shared definitions for the I2C EEPROM target: FSM states, default device address and ACK level.
package iic_eeprom_slave_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV,
    ST_ACK_DEV,
    ST_AH,
    ST_ACK_AH,
    ST_AL,
    ST_ACK_AL,
    ST_WR,
    ST_ACK_WR,
    ST_RD,
    ST_MACK,
    ST_WAIT_STOP
  } iic_state_e;

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'b1010_011;
  localparam logic       ACK_BIT          = 1'b0;

  function automatic logic addr_match(input logic [7:0] hdr, input logic [6:0] dev);
    return hdr[7:1] == dev;
  endfunction

endpackage

// File: rtl/iic_eeprom_slave_if.sv
// Bus-side signal bundle of the I2C EEPROM target (SCL/SDA plus the RAM write strobe).
interface iic_eeprom_slave_if #(
  parameter int MEM_AW = 8
) ();
  logic              scl;
  logic              sda_i;
  logic              sda_oe;
  logic              busy;
  logic              wr_stb;
  logic [MEM_AW-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (
    output scl, sda_i,
    input  sda_oe, busy, wr_stb, wr_addr, wr_data
  );

  modport slave (
    input  scl, sda_i,
    output sda_oe, busy, wr_stb, wr_addr, wr_data
  );
endinterface

// File: rtl/iic_eeprom_slave_line_sync.sv
// SCL/SDA synchroniser with single-clock SCL edge pulses and START/STOP detection.
module iic_eeprom_slave_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);
  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_s;

  // Reset to the idle-bus level so releasing reset never fakes an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_o      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_o;
  assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_o;

endmodule

// File: rtl/iic_eeprom_slave.sv
// I2C target emulating a 24Cxx EEPROM with a two-byte word address and internal RAM.
// Define IIC_SLAVE_PAGE_WRAP_EN to confine write-pointer increments to a PAGE_SIZE page.
module iic_eeprom_slave
  import iic_eeprom_slave_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DEV_ADDR_DEFAULT,
  parameter int         MEM_AW      = 8,
  parameter int         PAGE_SIZE   = 32,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  iic_eeprom_slave_if.slave bus
);

  if (SYNC_STAGES < 2 || MEM_AW < 1 || MEM_AW > 16 || PAGE_SIZE < 1 ||
      (PAGE_SIZE & (PAGE_SIZE - 1)) != 0) begin : g_bad_cfg
    $error("iic_eeprom_slave: unsupported parameter set");
  end

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  iic_eeprom_slave_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (bus.scl),
    .sda_i     (bus.sda_i),
    .sda_o     (sda_s),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start_det),
    .stop_o    (stop_det)
  );

  iic_state_e        state_q;
  logic              sda_oe_q, busy_q, wr_stb_q, rw_q, mack_q, fall_d1_q;
  logic [MEM_AW-1:0] wr_addr_q, ptr_q, ptr_wr_d, ptr_rd_d;
  logic [7:0]        wr_data_q, shift_q, tx_q, rd_byte;
  logic [3:0]        cnt_q;
  logic [7:0]        mem [0:2**MEM_AW-1];

  assign ptr_rd_d = ptr_q + MEM_AW'(1);
`ifdef IIC_SLAVE_PAGE_WRAP_EN
  localparam logic [MEM_AW-1:0] PAGE_MASK = MEM_AW'(PAGE_SIZE - 1);
  assign ptr_wr_d = (ptr_q & ~PAGE_MASK) | (ptr_rd_d & PAGE_MASK);
`else
  assign ptr_wr_d = ptr_rd_d;
`endif

  // The RAM is written from the registered strobe, one clock after it is presented.
  always_ff @(posedge clk) begin
    if (wr_stb_q) mem[wr_addr_q] <= wr_data_q;
  end

  assign rd_byte = mem[ptr_q];

  // SDA only ever changes on fall_d1_q, one clock after the synchronised SCL fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      shift_q   <= '0;
      tx_q      <= '0;
      rw_q      <= 1'b0;
      mack_q    <= 1'b0;
      fall_d1_q <= 1'b0;
    end else begin
      wr_stb_q  <= 1'b0;
      fall_d1_q <= scl_fall;
      if (stop_det) begin
        state_q  <= ST_IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (start_det) begin
        state_q  <= ST_DEV;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
        cnt_q    <= '0;
      end else begin
        case (state_q)
          ST_DEV, ST_AH, ST_AL, ST_WR: begin
            if (scl_rise && cnt_q != 4'd8) begin
              shift_q <= {shift_q[6:0], sda_s};
              cnt_q   <= cnt_q + 4'd1;
              if (state_q == ST_WR && cnt_q == 4'd7) begin
                wr_stb_q  <= 1'b1;
                wr_addr_q <= ptr_q;
                wr_data_q <= {shift_q[6:0], sda_s};
                ptr_q     <= ptr_wr_d;
              end
            end
            if (fall_d1_q && cnt_q == 4'd8) begin
              cnt_q <= '0;
              if (state_q == ST_DEV) begin
                if (addr_match(shift_q, DEV_ADDR)) begin
                  sda_oe_q <= 1'b1;
                  busy_q   <= 1'b1;
                  rw_q     <= shift_q[0];
                  state_q  <= ST_ACK_DEV;
                end else begin
                  state_q  <= ST_WAIT_STOP;
                end
              end else if (state_q == ST_AH) begin
                ptr_q    <= MEM_AW'(shift_q);
                sda_oe_q <= 1'b1;
                state_q  <= ST_ACK_AH;
              end else if (state_q == ST_AL) begin
                // Upper word-address bits beyond MEM_AW fall off the truncation.
                ptr_q    <= MEM_AW'({ptr_q, shift_q});
                sda_oe_q <= 1'b1;
                state_q  <= ST_ACK_AL;
              end else begin
                sda_oe_q <= 1'b1;
                state_q  <= ST_ACK_WR;
              end
            end
          end
          ST_ACK_DEV: begin
            if (fall_d1_q) begin
              cnt_q <= '0;
              if (rw_q) begin
                tx_q     <= rd_byte;
                sda_oe_q <= ~rd_byte[7];
                state_q  <= ST_RD;
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= ST_AH;
              end
            end
          end
          ST_ACK_AH: begin
            if (fall_d1_q) begin
              sda_oe_q <= 1'b0;
              state_q  <= ST_AL;
            end
          end
          ST_ACK_AL, ST_ACK_WR: begin
            if (fall_d1_q) begin
              sda_oe_q <= 1'b0;
              state_q  <= ST_WR;
            end
          end
          ST_RD: begin
            if (scl_rise) cnt_q <= cnt_q + 4'd1;
            if (fall_d1_q) begin
              if (cnt_q == 4'd8) begin
                sda_oe_q <= 1'b0;
                ptr_q    <= ptr_rd_d;
                cnt_q    <= '0;
                state_q  <= ST_MACK;
              end else begin
                tx_q     <= {tx_q[6:0], 1'b0};
                sda_oe_q <= ~tx_q[6];
              end
            end
          end
          ST_MACK: begin
            if (scl_rise) mack_q <= (sda_s == ACK_BIT);
            if (fall_d1_q) begin
              if (mack_q) begin
                tx_q     <= rd_byte;
                sda_oe_q <= ~rd_byte[7];
                state_q  <= ST_RD;
              end else begin
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
                state_q  <= ST_WAIT_STOP;
              end
            end
          end
          ST_IDLE, ST_WAIT_STOP: ;
          default: begin
            state_q  <= ST_IDLE;
            sda_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.sda_oe  = sda_oe_q;
  assign bus.busy    = busy_q;
  assign bus.wr_stb  = wr_stb_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

endmodule
